// File: rtl/jump_sequencer_if.sv
// Bundle of game-control inputs and status outputs for jump_sequencer.
// master drives press/tick/platform inputs; slave is the sequencer.
interface jump_sequencer_if #(
    parameter int X_W     = 10,
    parameter int SCORE_W = 8
);
    logic               start;
    logic               tick;
    logic               is_pressing;
    logic [3:0]         press_time;
    logic [X_W-1:0]     plat_lo;
    logic [X_W-1:0]     plat_hi;
    logic [X_W-1:0]     player_x;
    logic [3:0]         charge_level;
    logic [2:0]         state;
    logic               jumping;
    logic               land_pulse;
    logic [SCORE_W-1:0] score;
    logic               game_over;

    modport master (
        output start, tick, is_pressing, press_time, plat_lo, plat_hi,
        input  player_x, charge_level, state, jumping, land_pulse,
        input  score, game_over
    );

    modport slave (
        input  start, tick, is_pressing, press_time, plat_lo, plat_hi,
        output player_x, charge_level, state, jumping, land_pulse,
        output score, game_over
    );
endinterface

// File: rtl/jump_sequencer.sv
// One-round jump controller: charge from press length, move on ticks,
// judge the landing against the platform window and keep score.
module jump_sequencer #(
    parameter int X_W        = 10,
    parameter int DIST_SCALE = 8,
    parameter int STEP       = 2,
    parameter int X_START    = 40,
    parameter int SCORE_W    = 8
) (
    input logic             clk,
    input logic             rst,
    jump_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READY  = 3'd1,
        CHARGE = 3'd2,
        JUMP   = 3'd3,
        LAND   = 3'd4,
        OVER   = 3'd5
    } state_e;

    localparam logic [X_W-1:0]     X_MAX     = '1;
    localparam logic [X_W-1:0]     X_INIT    = X_W'(X_START);
    localparam logic [X_W-1:0]     STEP_X    = X_W'(STEP);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_e             state_q, state_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [X_W-1:0]     rem_q, rem_d;
    logic [3:0]         charge_q, charge_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               land_pulse_q, land_pulse_d;

    logic [35:0]    dist_full;
    logic [X_W-1:0] dist_sat;
    logic [X_W-1:0] move;
    logic [X_W:0]   sum;
    logic           hit;

    // Distance is taken from the latched charge, not the live press_time.
    assign dist_full = 36'(charge_q) * 36'(DIST_SCALE);
    assign dist_sat  = (dist_full > 36'(X_MAX)) ? X_MAX
                                                : dist_full[X_W-1:0];

    assign move = (rem_q < STEP_X) ? rem_q : STEP_X;
    assign sum  = {1'b0, x_q} + {1'b0, move};
    assign hit  = (bus.plat_lo <= x_q) && (x_q <= bus.plat_hi);

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        rem_d        = rem_q;
        charge_d     = charge_q;
        score_d      = score_q;
        land_pulse_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = READY;
                    x_d     = X_INIT;
                    score_d = '0;
                end
            end
            READY: begin
                if (bus.is_pressing) state_d = CHARGE;
            end
            CHARGE: begin
                if (bus.is_pressing) begin
                    charge_d = bus.press_time;
                end else if (charge_q == 4'd0) begin
                    state_d = READY;
                end else begin
                    state_d = JUMP;
                    rem_d   = dist_sat;
                end
            end
            JUMP: begin
                if (rem_q == '0) begin
                    state_d  = LAND;
                    charge_d = 4'd0;
                end else if (bus.tick) begin
                    if (sum[X_W]) begin
                        x_d   = X_MAX;
                        rem_d = '0;
                    end else begin
                        x_d   = sum[X_W-1:0];
                        rem_d = rem_q - move;
                    end
                end
            end
            LAND: begin
                if (hit) begin
                    state_d      = READY;
                    land_pulse_d = 1'b1;
                    if (score_q != SCORE_MAX)
                        score_d = score_q + SCORE_W'(1);
                end else begin
                    state_d = OVER;
                end
            end
            OVER: begin
                if (bus.start) begin
                    state_d = READY;
                    x_d     = X_INIT;
                    score_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            x_q          <= X_INIT;
            rem_q        <= '0;
            charge_q     <= 4'd0;
            score_q      <= '0;
            land_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            rem_q        <= rem_d;
            charge_q     <= charge_d;
            score_q      <= score_d;
            land_pulse_q <= land_pulse_d;
        end
    end

    assign bus.state        = state_q;
    assign bus.player_x     = x_q;
    assign bus.charge_level = charge_q;
    assign bus.score        = score_q;
    assign bus.land_pulse   = land_pulse_q;
    assign bus.jumping      = (state_q == JUMP);
    assign bus.game_over    = (state_q == OVER);
endmodule

// File: doc/jump_sequencer.md
Name: jump_sequencer

Overview:
- Game-level controller for one jump round; consumes the press-duration outputs of the button press logic (is_pressing, press_time).
- Sequences CHARGE -> JUMP -> LAND: converts released press length into a jump distance, advances the player x-position on frame ticks, judges landing against the current platform window.
- Drives score and game-over status to the display/VGA side; platform bounds come from the platform generator.

Parameters:
- X_W, 10, width of x-position, distance and platform-bound buses.
- DIST_SCALE, 8, pixels of jump distance per press_time unit.
- STEP, 2, maximum pixels moved per frame tick.
- X_START, 40, player x after reset/start.
- SCORE_W, 8, score counter width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately).
- start  in  1  one-cycle pulse, begin/restart game.
- tick  in  1  one-cycle frame-tick pulse, paces JUMP motion.
- is_pressing  in  1  button currently held (from press logic).
- press_time  in  4  current press duration 0..15 (from press logic).
- plat_lo  in  X_W  landing window low bound, inclusive.
- plat_hi  in  X_W  landing window high bound, inclusive.
- player_x  out  X_W  current player x.
- charge_level  out  4  registered press_time captured while charging.
- state  out  3  IDLE=0, READY=1, CHARGE=2, JUMP=3, LAND=4, OVER=5.
- jumping  out  1  high while state==JUMP.
- land_pulse  out  1  one-cycle pulse on successful landing.
- score  out  SCORE_W  successful landings this game.
- game_over  out  1  high while state==OVER.

Behaviour:
- Reset (rst=0, async): state=IDLE, player_x=X_START, charge_level=0, score=0, land_pulse=0, game_over=0, remaining distance=0. Reset mid-JUMP aborts the jump with no score change.
- IDLE: start -> READY next edge; player_x=X_START, score=0.
- READY: is_pressing=1 -> CHARGE next edge.
- CHARGE:
  - each cycle with is_pressing=1, charge_level<=press_time.
  - first cycle with is_pressing=0 is the release. The distance uses the registered charge_level, never the press_time sampled at release.
  - release with charge_level=0 -> READY, no motion, charge_level stays 0.
  - release with charge_level>0 -> JUMP next edge; remaining=charge_level*DIST_SCALE, computed at X_W bits and saturated to 2^X_W-1.
  - charge_level clears to 0 on entry to LAND.
- JUMP:
  - on each tick: move=min(STEP, remaining); player_x+=move; remaining-=move.
  - if player_x+move would exceed 2^X_W-1: player_x=2^X_W-1, remaining=0.
  - is_pressing and start ignored; cycles without tick hold state.
  - remaining==0 -> LAND on the next edge, i.e. the edge after the final move.
- LAND: exactly one cycle.
  - hit (plat_lo<=player_x<=plat_hi, unsigned): score+=1, saturating at 2^SCORE_W-1; land_pulse=1 for this one cycle; -> READY.
  - miss: -> OVER.
  - plat_lo>plat_hi is always a miss.
- OVER: game_over=1; player_x frozen; start -> READY next edge with player_x=X_START, score=0, game_over=0.
- start is ignored in READY, CHARGE, JUMP and LAND.
- tick coincident with the CHARGE->JUMP transition is not consumed; motion begins on the first tick seen in JUMP.
- All outputs registered; no combinational input->output paths.

Test Plan:
- Async reset: hold rst=0 during JUMP, between clk edges -> outputs return to reset values immediately (state=0, player_x=40, score=0) without waiting for clk.
- Normal hit, defaults: start; press until press_time=5; release; plat 70..90 -> 20 ticks, player_x 40->80; LAND one cycle; land_pulse high 1 cycle; score=1; state=READY.
- Miss/restart: same jump, plat 100..120 -> state=OVER, game_over=1, player_x=80; start -> state=READY, player_x=40, score=0, game_over=0.
- Zero press: is_pressing pulse with press_time held 0 -> CHARGE then READY; player_x unchanged; no land_pulse.
- Odd remainder: STEP=3, press_time=5 -> 13 ticks of +3 then 1 tick of +1; player_x=80 after 14 ticks.
- Ignored inputs and saturation: toggle is_pressing/start during JUMP -> no effect. X_W=8, press_time=15, X_START=240 -> player_x saturates at 255, LAND follows.
